// File: rtl/seq_mul_accum_if.sv
// Bus bundle for seq_mul_accum: product input stream, batch-result valid/ready and status.
// The slave modport is the accumulator side; master is the producer/consumer side.
interface seq_mul_accum_if #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
);
  logic              clear;
  logic [CNT_W-1:0]  len;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              ovf;
  logic              dropped;

  modport master (
    output clear, len, prod_in, prod_valid, out_ready,
    input  out_data, out_valid, busy, count, ovf, dropped
  );

  modport slave (
    input  clear, len, prod_in, prod_valid, out_ready,
    output out_data, out_valid, busy, count, ovf, dropped
  );
endinterface

// File: rtl/seq_mul_accum.sv
// Batch accumulator for sequential-multiplier products; presents each batch sum with valid/ready.
// Optional SATURATE_EN: clamp the accumulator at all-ones on carry instead of wrapping.
module seq_mul_accum #(
  parameter int PROD_W = 8,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 4
) (
  input  logic           clk,
  input  logic           rst,
  seq_mul_accum_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   len_q;
  logic               ovf_q;
  logic               out_valid_q;
  logic               busy_q;
  logic               dropped_q;

  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_next;
  logic [CNT_W-1:0]   cnt_inc;

  // The extra sum bit is the carry out of the accumulator width.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    sum      = {1'b0, acc} + (ACC_W+1)'(bus.prod_in);
    acc_next = sum[ACC_W-1:0];
`ifdef SATURATE_EN
    if (sum[ACC_W]) acc_next = '1;
`endif
    cnt_inc  = cnt + CNT_W'(1);
  end

  // len_q == 0 encodes a full 2**CNT_W batch: cnt_inc wraps to 0 on the last product.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    if (rst) begin
      state       <= IDLE;
      acc         <= '0;
      cnt         <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      dropped_q   <= 1'b0;
    end else begin
      dropped_q <= 1'b0;
      if (bus.clear) begin
        state       <= IDLE;
        acc         <= '0;
        cnt         <= '0;
        ovf_q       <= 1'b0;
        out_valid_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.prod_valid) begin
              acc   <= ACC_W'(bus.prod_in);
              cnt   <= CNT_W'(1);
              len_q <= bus.len;
              ovf_q <= 1'b0;
              if (bus.len == CNT_W'(1)) begin
                state       <= DONE;
                out_valid_q <= 1'b1;
              end else begin
                state  <= ACCUM;
                busy_q <= 1'b1;
              end
            end
          end
          ACCUM: begin
            if (bus.prod_valid) begin
              acc <= acc_next;
              cnt <= cnt_inc;
              if (sum[ACC_W]) ovf_q <= 1'b1;
              if (cnt_inc == len_q) begin
                state       <= DONE;
                busy_q      <= 1'b0;
                out_valid_q <= 1'b1;
              end
            end
          end
          DONE: begin
            // A product arriving while the result waits has nowhere to go.
            if (bus.prod_valid) dropped_q <= 1'b1;
            if (bus.out_ready) begin
              state       <= IDLE;
              out_valid_q <= 1'b0;
              cnt         <= '0;
            end
          end
          default: begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.out_data  = acc;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.count     = cnt;
  assign bus.ovf       = ovf_q;
  assign bus.dropped   = dropped_q;

endmodule
